// File: rtl/meta_update_sched_pkg.sv
// Shared types and constants for the meta-predictor update scheduler.
// The meta table holds one 2-bit counter per index. Counter bit [1] set
// means "prefer the global predictor".
package meta_update_sched_pkg;

  localparam int         IDX_W    = 10;
  localparam logic [1:0] CTR_MIN  = 2'd0;
  localparam logic [1:0] CTR_MAX  = 2'd3;
  localparam logic [1:0] CTR_INIT = 2'b10;

  typedef enum logic [2:0] {
    INIT = 3'd0,
    IDLE = 3'd1,
    RD   = 3'd2,
    MOD  = 3'd3,
    WR   = 3'd4
  } state_t;

  // One resolved branch waiting to train the meta table
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             local_ok;
    logic             global_ok;
  } res_entry_t;

endpackage

// File: rtl/meta_update_sched_sat_counter2.sv
// Saturating 2-bit up/down counter step used to train one meta-table entry.
// inc and dec together (or neither) leave the value unchanged.
module sat_counter2
  import meta_update_sched_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] nxt
);

  // Next counter value, clamped to [CTR_MIN, CTR_MAX]
  always_comb begin
    nxt = cur;
    if (inc && !dec) begin
      if (cur == CTR_MAX) begin
        nxt = CTR_MAX;
      end else begin
        nxt = cur + 2'd1;
      end
    end else if (dec && !inc) begin
      if (cur == CTR_MIN) begin
        nxt = CTR_MIN;
      end else begin
        nxt = cur - 2'd1;
      end
    end else begin
      nxt = cur;
    end
  end

endmodule

// File: rtl/meta_update_sched.sv
// Meta-predictor update scheduler.
// Initialises the meta table after reset, serves prediction lookups with
// one-cycle latency, and trains the table from a queue of resolved branches
// by read-modify-write through the single table port. Lookups always win
// the table port; a pending write waits in WR until the port is free.
// Optional feature: define META_UPDATE_BYPASS_EN to forward the freshly
// computed counter to lookups that hit the in-flight index in MOD/WR.
module meta_update_sched
  import meta_update_sched_pkg::*;
#(
  parameter int TBL_DEPTH  = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Lookup_valid,
  input  logic [31:0]      Lookup_addr,
  output logic             Lookup_resp_valid,
  output logic             Use_global,
  input  logic             Resolve_valid,
  input  logic [31:0]      Resolve_addr,
  input  logic             Resolve_local_correct,
  input  logic             Resolve_global_correct,
  output logic             Resolve_ready,
  output logic             Tbl_en,
  output logic             Tbl_we,
  output logic [IDX_W-1:0] Tbl_idx,
  output logic [1:0]       Tbl_wdata,
  input  logic [1:0]       Tbl_rdata
);

  localparam int               PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int               CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [IDX_W-1:0] INIT_LAST = IDX_W'(TBL_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  state_t           state_r;
  logic [IDX_W-1:0] init_idx_r;
  res_entry_t       fifo_r [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [1:0]       cur_r;
  logic             resp_valid_r;
  logic             resp_tbl_r;
  logic             byp_hit_r;
  logic             byp_bit_r;

  res_entry_t       head_s;
  logic             empty_s;
  logic             full_s;
  logic             head_agree_s;
  logic             push_s;
  logic             pop_s;
  logic             rd_issue_s;
  logic             bypass_hit_s;
  logic [1:0]       new_val_s;
  logic [IDX_W-1:0] lookup_idx_s;
  logic             unused_addr_bits_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  assign head_s        = fifo_r[rd_ptr_r];
  assign empty_s       = (count_r == {CNT_W{1'b0}});
  assign full_s        = (count_r == CNT_FULL);
  assign head_agree_s  = (head_s.local_ok == head_s.global_ok);
  assign lookup_idx_s  = Lookup_addr[11:2];
  assign Resolve_ready = !full_s && (state_r != INIT);
  assign push_s        = Resolve_valid && Resolve_ready;
  // Agreeing heads carry no training information and retire immediately
  assign rd_issue_s    = (state_r == IDLE) && !empty_s && !head_agree_s && !Lookup_valid;
  assign pop_s         = ((state_r == IDLE) && !empty_s && head_agree_s) ||
                         ((state_r == WR) && !Lookup_valid);
  assign Lookup_resp_valid  = resp_valid_r;
  assign unused_addr_bits_s = ^{Lookup_addr[31:12], Lookup_addr[1:0],
                                Resolve_addr[31:12], Resolve_addr[1:0]};

`ifdef META_UPDATE_BYPASS_EN
  assign bypass_hit_s = Lookup_valid && ((state_r == MOD) || (state_r == WR)) &&
                        (lookup_idx_s == head_s.idx);
`else
  assign bypass_hit_s = 1'b0;
`endif

  sat_counter2 u_sat (
    .cur (cur_r),
    .inc (head_s.global_ok && !head_s.local_ok),
    .dec (head_s.local_ok && !head_s.global_ok),
    .nxt (new_val_s)
  );

  // Table port arbitration: INIT owns it, then lookups, then head read, then write-back
  always_comb begin
    Tbl_en    = 1'b0;
    Tbl_we    = 1'b0;
    Tbl_idx   = {IDX_W{1'b0}};
    Tbl_wdata = 2'b00;
    if (RESET) begin
      Tbl_en = 1'b0;
    end else if (state_r == INIT) begin
      Tbl_en    = 1'b1;
      Tbl_we    = 1'b1;
      Tbl_idx   = init_idx_r;
      Tbl_wdata = CTR_INIT;
    end else if (Lookup_valid) begin
      Tbl_en  = 1'b1;
      Tbl_idx = lookup_idx_s;
    end else if (rd_issue_s) begin
      Tbl_en  = 1'b1;
      Tbl_idx = head_s.idx;
    end else if (state_r == WR) begin
      Tbl_en    = 1'b1;
      Tbl_we    = 1'b1;
      Tbl_idx   = head_s.idx;
      Tbl_wdata = new_val_s;
    end else begin
      Tbl_en = 1'b0;
    end
  end

  // Prediction select: INIT-time lookups default to global, else forwarded or table value
  always_comb begin
    if (!resp_tbl_r) begin
      Use_global = 1'b1;
    end else if (byp_hit_r) begin
      Use_global = byp_bit_r;
    end else begin
      Use_global = Tbl_rdata[1];
    end
  end

  // Resolved-branch queue storage; occupancy lives in the control block below
  always_ff @(posedge CLK) begin
    if (push_s) begin
      fifo_r[wr_ptr_r] <= {Resolve_addr[11:2], Resolve_local_correct, Resolve_global_correct};
    end
  end

  // Control FSM, queue pointers and lookup response registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r      <= INIT;
      init_idx_r   <= {IDX_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      wr_ptr_r     <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      cur_r        <= CTR_INIT;
      resp_valid_r <= 1'b0;
      resp_tbl_r   <= 1'b0;
      byp_hit_r    <= 1'b0;
      byp_bit_r    <= 1'b0;
    end else begin
      resp_valid_r <= Lookup_valid;
      resp_tbl_r   <= Lookup_valid && (state_r != INIT);
      byp_hit_r    <= bypass_hit_s;
      byp_bit_r    <= new_val_s[1];
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CNT_W'(1);
      end else if (pop_s && !push_s) begin
        count_r <= count_r - CNT_W'(1);
      end
      case (state_r)
        INIT: begin
          init_idx_r <= init_idx_r + IDX_W'(1);
          if (init_idx_r == INIT_LAST) begin
            state_r <= IDLE;
          end
        end
        IDLE: begin
          if (rd_issue_s) begin
            state_r <= RD;
          end
        end
        RD: begin
          // Head read data is on the port now; a lookup issued this cycle lands next cycle
          cur_r   <= Tbl_rdata;
          state_r <= MOD;
        end
        MOD: begin
          state_r <= WR;
        end
        WR: begin
          if (!Lookup_valid) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= INIT;
        end
      endcase
    end
  end

endmodule
